// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with NRD asynchronous read ports,
// one write-back port with same-cycle bypass, and a per-register
// pending-write scoreboard that flags RAW hazards to the decode stage.
module regfile_sb #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 15,
    parameter int unsigned NRD        = 2,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned RESET_INIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_dest,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    input  logic [NRD-1:0]          rd_use,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    output logic                    hazard,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_dest,
    input  logic                    flush,
    output logic                    sb_err
);

    localparam int unsigned      AW1     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Architectural storage and scoreboard state
    logic [DATA_W-1:0] rf_q  [DEPTH];
    logic [DATA_W-1:0] rf_d  [DEPTH];
    logic [CNT_W-1:0]  cnt_q [DEPTH];
    logic [CNT_W-1:0]  cnt_d [DEPTH];
    logic              sb_err_q;
    logic              sb_err_d;

    // Address is implemented only below DEPTH; the rest of the space reads as 0
    function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
        return AW1'(a) < AW1'(DEPTH);
    endfunction

    // Write-back path: only implemented registers can match wb_dest
    always_comb begin
        rf_d = rf_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_en && (wb_dest == ADDR_W'(i))) begin
                rf_d[i] = wb_data;
            end
        end
    end

    // Pending counters: issue increments, write-back decrements, flush clears
    always_comb begin
        logic inc;
        logic dec;
        inc      = 1'b0;
        dec      = 1'b0;
        sb_err_d = sb_err_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            inc = iss_en && (iss_dest == ADDR_W'(i));
            dec = wb_en && (wb_dest == ADDR_W'(i)) && (cnt_q[i] != '0);
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc && !dec) begin
                // Saturate rather than wrap so the hazard stays asserted
                if (cnt_q[i] == CNT_MAX) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // State registers with asynchronous reset to the initial register image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i]  <= (RESET_INIT != 0) ? DATA_W'(i) : '0;
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            rf_q     <= rf_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Read ports: storage lookup, write-through bypass and busy/hazard flags
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  c;
        logic              byp;
        a       = '0;
        data    = '0;
        c       = '0;
        byp     = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        hazard  = 1'b0;
        for (int unsigned k = 0; k < NRD; k++) begin
            a    = rd_addr[k*ADDR_W +: ADDR_W];
            data = '0;
            c    = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (a == ADDR_W'(i)) begin
                    data = rf_q[i];
                    c    = cnt_q[i];
                end
            end
            byp = wb_en && (wb_dest == a) && addr_valid(a);
            if (byp) begin
                data = wb_data;
            end
            rd_data[k*DATA_W +: DATA_W] = data;
            // A single outstanding write retired this cycle is resolved by the bypass
            rd_busy[k] = (c > CNT_ONE) || ((c == CNT_ONE) && !byp);
            hazard     = hazard | (rd_use[k] & rd_busy[k]);
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with default parameters.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [7:0]  rd_addr;
    logic [1:0]  rd_use;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        iss_en;
    logic [3:0]  iss_dest;
    logic        flush;
    logic        sb_err;

    int checks;
    int errors;

    logic [31:0] rd0;
    logic [31:0] rd1;
    assign rd0 = rd_data[31:0];
    assign rd1 = rd_data[63:32];

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .rd_addr  (rd_addr),
        .rd_use   (rd_use),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .hazard   (hazard),
        .iss_en   (iss_en),
        .iss_dest (iss_dest),
        .flush    (flush),
        .sb_err   (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a new cycle: inputs change on the falling edge, all controls idle
    task automatic next_cycle();
        @(negedge clk);
        wb_en   = 1'b0;
        iss_en  = 1'b0;
        flush   = 1'b0;
        rd_use  = 2'b00;
        wb_dest = 4'd0;
        wb_data = 32'd0;
        iss_dest = 4'd0;
    endtask

    task automatic test_reset();
        next_cycle();
        rd_addr = {4'd14, 4'd3};
        #1;
        checks++;
        if (rd0 !== 32'd3) begin errors++; $display("FAIL reset_r3: got %h want %h", rd0, 32'd3); end
        checks++;
        if (rd1 !== 32'd14) begin errors++; $display("FAIL reset_r14: got %h want %h", rd1, 32'd14); end
        rd_addr = {4'd0, 4'd15};
        rd_use  = 2'b11;
        #1;
        checks++;
        if (rd0 !== 32'd0) begin errors++; $display("FAIL reset_r15_data: got %h want %h", rd0, 32'd0); end
        checks++;
        if (rd_busy !== 2'b00 || hazard !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got busy=%b hazard=%b want busy=00 hazard=0", rd_busy, hazard);
        end
        checks++;
        if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", sb_err); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_invalid();
        // Five issues to R15 would overflow a real counter; they must be ignored
        for (int n = 0; n < 5; n++) begin
            next_cycle();
            iss_en   = 1'b1;
            iss_dest = 4'd15;
            wb_en    = 1'b1;
            wb_dest  = 4'd15;
            wb_data  = 32'hCAFE_0000;
            rd_addr  = {4'd15, 4'd15};
            rd_use   = 2'b11;
            #1;
            if (n == 0) begin
                checks++;
                if (rd0 !== 32'd0 || rd1 !== 32'd0) begin
                    errors++; $display("FAIL invalid_no_bypass: got %h/%h want 0/0", rd0, rd1);
                end
            end
        end
        next_cycle();
        rd_addr = {4'd15, 4'd15};
        rd_use  = 2'b11;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || hazard !== 1'b0 || rd0 !== 32'd0) begin
            errors++; $display("FAIL invalid_state: got busy=%b hazard=%b data=%h want 00/0/0", rd_busy, hazard, rd0);
        end
        checks++;
        if (sb_err !== 1'b0) begin errors++; $display("FAIL invalid_sb_err: got %b want 0", sb_err); end
    endtask

    task automatic test_bypass();
        next_cycle();
        wb_en   = 1'b1;
        wb_dest = 4'd5;
        wb_data = 32'hDEAD_BEEF;
        rd_addr = {4'd6, 4'd5};
        #1;
        checks++;
        if (rd0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h want %h", rd0, 32'hDEAD_BEEF); end
        checks++;
        if (rd1 !== 32'd6) begin errors++; $display("FAIL bypass_other_port: got %h want %h", rd1, 32'd6); end
        next_cycle();
        rd_addr = {4'd5, 4'd5};
        #1;
        checks++;
        if (rd0 !== 32'hDEAD_BEEF || rd1 !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bypass_stored: got %h/%h want %h", rd0, rd1, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_issue_hazard();
        next_cycle();
        iss_en   = 1'b1;
        iss_dest = 4'd2;
        rd_addr  = {4'd2, 4'd0};
        rd_use   = 2'b10;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL issue_same_cycle_hazard: got %b want 0", hazard); end
        next_cycle();
        rd_addr = {4'd2, 4'd0};
        rd_use  = 2'b10;
        #1;
        checks++;
        if (hazard !== 1'b1 || rd_busy !== 2'b10) begin
            errors++; $display("FAIL issue_hazard: got hazard=%b busy=%b want 1/10", hazard, rd_busy);
        end
        rd_use = 2'b00;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL issue_unused_port: got %b want 0", hazard); end
        next_cycle();
        wb_en   = 1'b1;
        wb_dest = 4'd2;
        wb_data = 32'h1234_5678;
        rd_addr = {4'd2, 4'd0};
        rd_use  = 2'b10;
        #1;
        checks++;
        if (hazard !== 1'b0 || rd1 !== 32'h1234_5678) begin
            errors++; $display("FAIL issue_wb_resolve: got hazard=%b data=%h want 0/%h", hazard, rd1, 32'h1234_5678);
        end
        next_cycle();
        rd_addr = {4'd2, 4'd2};
        rd_use  = 2'b11;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || hazard !== 1'b0 || rd0 !== 32'h1234_5678) begin
            errors++; $display("FAIL issue_cleared: got busy=%b hazard=%b data=%h want 00/0/%h", rd_busy, hazard, rd0, 32'h1234_5678);
        end
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            iss_en   = 1'b1;
            iss_dest = 4'd4;
        end
        next_cycle();
        rd_addr = {4'd0, 4'd4};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || sb_err !== 1'b0) begin
            errors++; $display("FAIL ovf_before: got busy=%b sb_err=%b want 1/0", rd_busy[0], sb_err);
        end
        iss_en   = 1'b1;
        iss_dest = 4'd4;
        next_cycle();
        rd_addr = {4'd0, 4'd4};
        #1;
        checks++;
        if (sb_err !== 1'b1) begin errors++; $display("FAIL ovf_sb_err: got %b want 1", sb_err); end
        // Counter held at 3: two write-backs leave it busy, the third resolves it
        for (int n = 0; n < 3; n++) begin
            if (n > 0) next_cycle();
            wb_en   = 1'b1;
            wb_dest = 4'd4;
            wb_data = 32'h0000_0040 + 32'(n);
            rd_addr = {4'd0, 4'd4};
            #1;
            checks++;
            if (rd_busy[0] !== ((n < 2) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL ovf_drain_%0d: got busy=%b want %b", n, rd_busy[0], (n < 2) ? 1'b1 : 1'b0);
            end
        end
        next_cycle();
        rd_addr = {4'd0, 4'd4};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd0 !== 32'h0000_0042 || sb_err !== 1'b1) begin
            errors++; $display("FAIL ovf_after: got busy=%b data=%h sb_err=%b want 0/%h/1", rd_busy[0], rd0, sb_err, 32'h42);
        end
    endtask

    task automatic test_same_cycle();
        next_cycle();
        iss_en   = 1'b1;
        iss_dest = 4'd7;
        next_cycle();
        iss_en   = 1'b1;
        iss_dest = 4'd7;
        wb_en    = 1'b1;
        wb_dest  = 4'd7;
        wb_data  = 32'h0000_0077;
        rd_addr  = {4'd0, 4'd7};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd0 !== 32'h0000_0077) begin
            errors++; $display("FAIL same_cycle_bypass: got busy=%b data=%h want 0/%h", rd_busy[0], rd0, 32'h77);
        end
        next_cycle();
        rd_addr = {4'd0, 4'd7};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd0 !== 32'h0000_0077) begin
            errors++; $display("FAIL same_cycle_after: got busy=%b data=%h want 1/%h", rd_busy[0], rd0, 32'h77);
        end
        wb_en   = 1'b1;
        wb_dest = 4'd7;
        wb_data = 32'h0000_0078;
        next_cycle();
        rd_addr = {4'd0, 4'd7};
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd0 !== 32'h0000_0078) begin
            errors++; $display("FAIL same_cycle_drain: got busy=%b data=%h want 0/%h", rd_busy[0], rd0, 32'h78);
        end
    endtask

    task automatic test_flush();
        next_cycle(); iss_en = 1'b1; iss_dest = 4'd1;
        next_cycle(); iss_en = 1'b1; iss_dest = 4'd1;
        next_cycle(); iss_en = 1'b1; iss_dest = 4'd9;
        next_cycle();
        rd_addr = {4'd9, 4'd1};
        rd_use  = 2'b11;
        #1;
        checks++;
        if (rd_busy !== 2'b11 || hazard !== 1'b1) begin
            errors++; $display("FAIL flush_before: got busy=%b hazard=%b want 11/1", rd_busy, hazard);
        end
        iss_en   = 1'b1;
        iss_dest = 4'd1;
        flush    = 1'b1;
        wb_en    = 1'b1;
        wb_dest  = 4'd9;
        wb_data  = 32'h0000_0099;
        next_cycle();
        rd_addr = {4'd9, 4'd1};
        rd_use  = 2'b11;
        #1;
        checks++;
        if (rd_busy !== 2'b00 || hazard !== 1'b0) begin
            errors++; $display("FAIL flush_cleared: got busy=%b hazard=%b want 00/0", rd_busy, hazard);
        end
        checks++;
        if (rd1 !== 32'h0000_0099 || sb_err !== 1'b1) begin
            errors++; $display("FAIL flush_data_err: got data=%h sb_err=%b want %h/1", rd1, sb_err, 32'h99);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle(); iss_en = 1'b1; iss_dest = 4'd3;
        next_cycle();
        wb_en   = 1'b1;
        wb_dest = 4'd0;
        wb_data = 32'h0000_AAAA;
        next_cycle();
        rd_addr = {4'd3, 4'd0};
        #1;
        checks++;
        if (rd0 !== 32'h0000_AAAA || rd_busy[1] !== 1'b1) begin
            errors++; $display("FAIL rstmid_before: got data=%h busy=%b want %h/1", rd0, rd_busy[1], 32'hAAAA);
        end
        rst      = 1'b1;
        wb_en    = 1'b1;
        wb_dest  = 4'd0;
        wb_data  = 32'h0000_BBBB;
        iss_en   = 1'b1;
        iss_dest = 4'd3;
        rd_addr  = {4'd5, 4'd4};
        #1;
        checks++;
        if (rd1 !== 32'd5 || sb_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_immediate: got r5=%h sb_err=%b want 5/0", rd1, sb_err);
        end
        @(posedge clk);
        #1;
        wb_en   = 1'b0;
        iss_en  = 1'b0;
        rd_addr = {4'd3, 4'd0};
        rd_use  = 2'b10;
        #1;
        checks++;
        if (rd0 !== 32'd0 || rd1 !== 32'd3 || rd_busy !== 2'b00 || hazard !== 1'b0) begin
            errors++; $display("FAIL rstmid_override: got r0=%h r3=%h busy=%b hazard=%b want 0/3/00/0", rd0, rd1, rd_busy, hazard);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        wb_en    = 1'b0;
        wb_dest  = 4'd0;
        wb_data  = 32'd0;
        rd_addr  = 8'd0;
        rd_use   = 2'b00;
        iss_en   = 1'b0;
        iss_dest = 4'd0;
        flush    = 1'b0;
        test_reset();
        test_invalid();
        test_bypass();
        test_issue_hazard();
        test_overflow();
        test_same_cycle();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the ARM core's general-purpose register file. It provides `NRD` asynchronous read ports, one write-back port with same-cycle write-through bypass, and a per-register pending-write scoreboard. The decode stage uses the scoreboard's hazard flags to stall on RAW dependencies. It sits between ID (reads, issue marking) and WB (result write), and adds flush support for branch mispredicts.

## Interface
- `DATA_W`, 32, register width.
- `ADDR_W`, 4, register address width.
- `DEPTH`, 15, number of implemented registers, 1..2^ADDR_W (R0..R14; R15/PC lives outside).
- `NRD`, 2, number of read ports.
- `CNT_W`, 2, width of per-register pending counter.
- `RESET_INIT`, 1, 1: register i resets to value i; 0: all registers reset to 0.

- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wb_en` in 1: write-back enable.
- `wb_dest` in ADDR_W: write-back register.
- `wb_data` in DATA_W: write-back value.
- `rd_addr` in NRD*ADDR_W: read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- `rd_use` in NRD: port k operand actually consumed this cycle.
- `rd_data` out NRD*DATA_W: read data, port k at [k*DATA_W +: DATA_W].
- `rd_busy` out NRD: port k's register has an unresolved pending write.
- `hazard` out 1: OR over k of (`rd_use[k]` & `rd_busy[k]`).
- `iss_en` in 1: an instruction writing `iss_dest` leaves ID this cycle.
- `iss_dest` in ADDR_W: destination being marked pending.
- `flush` in 1: synchronous clear of all pending counters.
- `sb_err` out 1: sticky error flag, set on pending-counter overflow.

## Operation
- Storage: DEPTH x DATA_W array and DEPTH x CNT_W pending counters `cnt[i]`.
- An address is valid iff it is < DEPTH. For invalid addresses:
  - reads return 0 and `rd_busy` = 0;
  - writes and issues are ignored, with no effect on `sb_err`.
- Write: at posedge, if `wb_en` and `wb_dest` is valid, then RF[`wb_dest`] <= `wb_data`.
- Read (combinational):
  - if `wb_en` and `wb_dest` == `rd_addr[k]` (valid), then `rd_data[k]` = `wb_data` (bypass);
  - otherwise `rd_data[k]` = RF[`rd_addr[k]`].
- Scoreboard, per register i at posedge:
  - `inc` = `iss_en` & (`iss_dest` == i);
  - `dec` = `wb_en` & (`wb_dest` == i) & (`cnt[i]` != 0);
  - `inc` & `dec`: unchanged;
  - `inc` only: if `cnt[i]` == 2^CNT_W-1, the counter holds and `sb_err` <= 1; otherwise `cnt[i]` + 1;
  - `dec` only: `cnt[i]` - 1.
  - A write-back to a register with `cnt` == 0 still writes data; the counter does not underflow.
- `flush`: all `cnt` <= 0. It has priority over a same-cycle `inc`/`dec`. Data writes in the flush cycle still occur. `sb_err` is not cleared by flush.
- `rd_busy[k]`:
  - `cnt[a]` > 1 → 1;
  - `cnt[a]` == 1 → 1, unless `wb_en` & `wb_dest` == a that cycle (bypass resolves it) → 0;
  - `cnt[a]` == 0 → 0.
- Read ports are fully independent; any number may alias the same register.

## Timing
- Reset (asynchronous, immediate):
  - RF[i] = i (RESET_INIT=1) or 0;
  - all `cnt` = 0;
  - `sb_err` = 0;
  - outputs follow combinationally: `rd_busy` = 0, `hazard` = 0, and `rd_data` = reset contents.
- Reset asserted mid-operation overrides any same-edge write, issue, or flush.
- Write latency:
  - 0 cycles via bypass on `rd_data`;
  - 1 edge to storage; a read in the next cycle sees the stored value.
- Issue latency: `cnt` increments at the edge ending the `iss_en` cycle, so `rd_busy` is visible from the next cycle.
- `hazard` is combinational from `rd_addr`, `rd_use`, `wb_*`, and `cnt`, with no registered delay.
- Simultaneous issue and write-back to the same register: the count is unchanged, and the data is written.

## Test plan
- Reset with RESET_INIT=1: read R3 and R14 → 3 and 14. Read address 15 → 0, `rd_busy` = 0, `sb_err` = 0.
- `wb_en`=1, `wb_dest`=5, `wb_data`=0xDEADBEEF, `rd_addr[0]`=5 in the same cycle → `rd_data[0]` = 0xDEADBEEF before the edge. Next cycle with `wb_en`=0 → still 0xDEADBEEF.
- Issue R2, then `rd_use[1]`=1 with `rd_addr[1]`=2 → `hazard`=1. In the WB cycle for R2, `hazard`=0 and the bypassed data appears. Next cycle `cnt[2]`=0.
- Issue R4 three times (CNT_W=2) → `cnt`=3. A fourth issue → `sb_err`=1 (sticky), `cnt` stays 3. Three write-backs → `cnt`=0, `rd_busy`=0.
- Issue R7 and write-back R7 in the same cycle while `cnt[7]`=1 → `cnt` stays 1 and RF[7] is updated.
- `cnt[1]`=2 and `cnt[9]`=1 plus a same-cycle issue R1, then `flush` → all `cnt`=0 and `hazard`=0. Assert `rst` mid-sequence → all registers and counters return to reset values immediately.
